// File: rtl/ninjin_ddr_sched.sv
// ninjin_ddr_sched: two-requester DDR scheduler that slices each transfer into bursts for one image master.
// Latency: request accepted -> ddr_req rises 2 edges later; ddr_done -> next ddr_req after one low cycle.
// Backpressure: a busy slot ignores req_valid; only one burst is in flight, so other slots wait in S_IDLE.
module ninjin_ddr_sched #(
   parameter int BURST_LEN = 256,
   parameter int DWIDTH    = 32,
   parameter int MEMSIZE   = 32,
   parameter int CNTW      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_mode,
   input  logic [2*MEMSIZE-1:0]   req_base,
   input  logic [2*CNTW-1:0]      req_nburst,
   output logic [1:0]             req_ack,
   output logic [1:0]             req_done,
   output logic [1:0]             req_busy,
   output logic [1:0]             grant,
   output logic                   ddr_req,
   output logic                   ddr_mode,
   output logic [MEMSIZE-1:0]     ddr_base,
   input  logic                   ddr_done,
   input  logic [3:0]             ddr_err,
   output logic [3:0]             err,
   output logic [1:0]             err_src
);

   // Byte stride between consecutive bursts of one transfer; wraps within the DDR address space.
   localparam logic [MEMSIZE-1:0] C_STRIDE = MEMSIZE'(BURST_LEN * DWIDTH / 8);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;

   // Per-requester slot: direction, current burst address, bursts still to issue.
   logic [1:0]         r_busy;
   logic [1:0]         r_mode;
   logic [MEMSIZE-1:0] r_base [2];
   logic [CNTW-1:0]    r_rem  [2];

   logic [1:0]         r_ack;
   logic [1:0]         r_done;
   logic               r_owner;   // slot owning the current burst
   logic               r_prio;    // slot that wins a tie in S_IDLE
   logic [3:0]         r_err;
   logic [1:0]         r_err_src;

   logic [1:0]         w_cand;
   logic [1:0]         w_accept;
   logic [1:0]         w_grant;
   logic [1:0]         w_end_oh;
   logic               w_pick;
   logic               w_burst_end;
   logic               w_burst_err;

   // A slot is a burst candidate only if it still has bursts left; zero-length slots retire on their own.
   assign w_cand      = {r_busy[1] & (r_rem[1] != '0), r_busy[0] & (r_rem[0] != '0)};
   assign w_accept    = req_valid & ~r_busy;
   assign w_pick      = w_cand[r_prio] ? r_prio : ~r_prio;
   assign w_burst_end = (r_state == S_WAIT) && ddr_done;
   assign w_burst_err = w_burst_end && (ddr_err != 4'd0);
   assign w_end_oh    = w_burst_end ? w_grant : 2'b00;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state: one burst per IDLE->ISSUE->WAIT round trip; ddr_done only counts in S_WAIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (|w_cand) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (ddr_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: master interface is driven from the owning slot only while a burst is in flight.
   always_comb begin
      ddr_req  = 1'b0;
      ddr_mode = 1'b0;
      ddr_base = '0;
      w_grant  = 2'b00;
      if (r_state != S_IDLE) begin
         ddr_req  = 1'b1;
         ddr_mode = r_mode[r_owner];
         ddr_base = r_base[r_owner];
         w_grant  = r_owner ? 2'b10 : 2'b01;
      end
   end

   // Round-robin at burst granularity: the slot just served drops to lowest priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= 1'b0;
         r_prio  <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_owner <= w_pick;
         end
         if (w_burst_end) begin
            r_prio <= ~r_owner;
         end
      end
   end

   // Slot bookkeeping: accept, retire zero-length transfers, and advance/abort on burst completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 2'b00;
         r_mode <= 2'b00;
         r_ack  <= 2'b00;
         r_done <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_base[i] <= '0;
            r_rem[i]  <= '0;
         end
      end else begin
         r_ack  <= 2'b00;
         r_done <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (w_accept[i]) begin
               r_busy[i] <= 1'b1;
               r_ack[i]  <= 1'b1;
               r_mode[i] <= req_mode[i];
               r_base[i] <= req_base[i*MEMSIZE +: MEMSIZE];
               r_rem[i]  <= req_nburst[i*CNTW +: CNTW];
            end else if (r_busy[i] && (r_rem[i] == '0)) begin
               r_busy[i] <= 1'b0;
               r_done[i] <= 1'b1;
            end else if (w_end_oh[i]) begin
               if (w_burst_err || (r_rem[i] == CNTW'(1))) begin
                  r_busy[i] <= 1'b0;
                  r_done[i] <= 1'b1;
                  r_rem[i]  <= '0;
               end else begin
                  r_rem[i]  <= r_rem[i] - CNTW'(1);
               end
               if (!w_burst_err) begin
                  r_base[i] <= r_base[i] + C_STRIDE;
               end
            end
         end
      end
   end

   // Sticky error: a new master error wins; otherwise it clears in step with the next accept pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err     <= 4'd0;
         r_err_src <= 2'b00;
      end else if (w_burst_err) begin
         r_err     <= ddr_err;
         r_err_src <= w_grant;
      end else if (|w_accept) begin
         r_err     <= 4'd0;
         r_err_src <= 2'b00;
      end
   end

   assign req_ack  = r_ack;
   assign req_done = r_done;
   assign req_busy = r_busy;
   assign grant    = w_grant;
   assign err      = r_err;
   assign err_src  = r_err_src;

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
// Directed bench for ninjin_ddr_sched: hand-computed vectors, immediate assertions per comparison.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The bench acts as the DDR master, answering each ddr_req rise with ddr_done 10 cycles later.
module tb_ninjin_ddr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_mode = 2'b00;
   logic [63:0] req_base = 64'd0;
   logic [31:0] req_nburst = 32'd0;
   logic [1:0]  req_ack, req_done, req_busy, grant;
   logic        ddr_req, ddr_mode;
   logic [31:0] ddr_base;
   logic        ddr_done = 1'b0;
   logic [3:0]  ddr_err = 4'd0;
   logic [3:0]  err;
   logic [1:0]  err_src;

   int n_cmp = 0;
   int n_fail = 0;

   ninjin_ddr_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_mode   (req_mode),
      .req_base   (req_base),
      .req_nburst (req_nburst),
      .req_ack    (req_ack),
      .req_done   (req_done),
      .req_busy   (req_busy),
      .grant      (grant),
      .ddr_req    (ddr_req),
      .ddr_mode   (ddr_mode),
      .ddr_base   (ddr_base),
      .ddr_done   (ddr_done),
      .ddr_err    (ddr_err),
      .err        (err),
      .err_src    (err_src)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait for a burst, check its attributes, complete it with ddr_done after 10 cycles.
   task automatic serve_burst(input string tag, input logic [1:0] g, input logic [31:0] b,
                              input logic m, input logic [3:0] e,
                              input logic [1:0] dn, input logic [1:0] by);
      int n;
      n = 0;
      while (ddr_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_rise"},  ddr_req,  32'd1);
      check({tag, "_grant"}, grant,    g);
      check({tag, "_base"},  ddr_base, b);
      check({tag, "_mode"},  ddr_mode, m);
      repeat (9) tick();
      check({tag, "_hold"},  ddr_req,  32'd1);
      ddr_done = 1'b1;
      ddr_err  = e;
      tick();
      ddr_done = 1'b0;
      ddr_err  = 4'd0;
      check({tag, "_gap"},   ddr_req,  32'd0);
      check({tag, "_gidle"}, grant,    32'd0);
      check({tag, "_done"},  req_done, dn);
      check({tag, "_busy"},  req_busy, by);
   endtask

   initial begin
      // ---- reset state ----
      rst = 1'b1;
      tick();
      tick();
      check("rst_ddr_req", ddr_req, 32'd0);
      check("rst_grant",   grant,   32'd0);
      check("rst_ack",     req_ack, 32'd0);
      check("rst_done",    req_done, 32'd0);
      check("rst_busy",    req_busy, 32'd0);
      check("rst_err",     err,     32'd0);
      check("rst_errsrc",  err_src, 32'd0);
      check("rst_base",    ddr_base, 32'd0);
      check("rst_mode",    ddr_mode, 32'd0);
      rst = 1'b0;
      tick();

      // ---- req0 write, 0x1000 x3, req_valid held high throughout ----
      req_valid  = 2'b01;
      req_mode   = 2'b01;
      req_base   = {32'd0, 32'h0000_1000};
      req_nburst = {16'd0, 16'd3};
      tick();
      check("t1_ack",   req_ack,  32'h1);
      check("t1_busy",  req_busy, 32'h1);
      check("t1_noreq", ddr_req,  32'd0);
      tick();
      check("t1_ack_once", req_ack, 32'h0);
      serve_burst("t1_b0", 2'b01, 32'h0000_1000, 1'b1, 4'd0, 2'b00, 2'b01);
      check("t1_held_noack", req_ack, 32'h0);
      serve_burst("t1_b1", 2'b01, 32'h0000_1400, 1'b1, 4'd0, 2'b00, 2'b01);
      serve_burst("t1_b2", 2'b01, 32'h0000_1800, 1'b1, 4'd0, 2'b01, 2'b00);
      // req_valid still high in the done cycle: accepted on the following edge
      check("t1_done_noack", req_ack, 32'h0);
      tick();
      check("t1_reacc_ack",  req_ack,  32'h1);
      check("t1_reacc_busy", req_busy, 32'h1);
      check("t1_done_once",  req_done, 32'h0);

      // ---- reset while a burst is in S_WAIT ----
      begin
         int n;
         n = 0;
         while (ddr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
      end
      check("t6_rise", ddr_req, 32'd1);
      tick();
      tick();
      rst       = 1'b1;
      req_valid = 2'b00;
      tick();
      check("t6_req",   ddr_req,  32'd0);
      check("t6_busy",  req_busy, 32'd0);
      check("t6_grant", grant,    32'd0);
      rst      = 1'b0;
      ddr_done = 1'b1;
      tick();
      ddr_done = 1'b0;
      check("t6_late_done", req_done, 32'd0);
      check("t6_late_busy", req_busy, 32'd0);
      check("t6_late_req",  ddr_req,  32'd0);
      tick();
      check("t6_still_idle", ddr_req, 32'd0);

      // ---- both requesters together, round robin ----
      req_valid  = 2'b11;
      req_mode   = 2'b10;
      req_base   = {32'h0000_8000, 32'h0000_0000};
      req_nburst = {16'd2, 16'd2};
      tick();
      req_valid = 2'b00;
      check("t2_ack",  req_ack,  32'h3);
      check("t2_busy", req_busy, 32'h3);
      serve_burst("t2_b0", 2'b01, 32'h0000_0000, 1'b0, 4'd0, 2'b00, 2'b11);
      serve_burst("t2_b1", 2'b10, 32'h0000_8000, 1'b1, 4'd0, 2'b00, 2'b11);
      serve_burst("t2_b2", 2'b01, 32'h0000_0400, 1'b0, 4'd0, 2'b01, 2'b10);
      serve_burst("t2_b3", 2'b10, 32'h0000_8400, 1'b1, 4'd0, 2'b10, 2'b00);

      // ---- req1 zero-length transfer ----
      req_valid  = 2'b10;
      req_mode   = 2'b00;
      req_nburst = {16'd0, 16'd0};
      tick();
      req_valid = 2'b00;
      check("t3_ack",  req_ack,  32'h2);
      check("t3_busy", req_busy, 32'h2);
      check("t3_req0", ddr_req,  32'd0);
      tick();
      check("t3_done", req_done, 32'h2);
      check("t3_clr",  req_busy, 32'h0);
      check("t3_req1", ddr_req,  32'd0);
      tick();
      check("t3_done_once", req_done, 32'h0);
      check("t3_req2", ddr_req, 32'd0);

      // ---- req0 address wrap ----
      req_valid  = 2'b01;
      req_mode   = 2'b00;
      req_base   = {32'd0, 32'hFFFF_FC00};
      req_nburst = {16'd0, 16'd2};
      tick();
      req_valid = 2'b00;
      check("t4_ack", req_ack, 32'h1);
      serve_burst("t4_b0", 2'b01, 32'hFFFF_FC00, 1'b0, 4'd0, 2'b00, 2'b01);
      serve_burst("t4_b1", 2'b01, 32'h0000_0000, 1'b0, 4'd0, 2'b01, 2'b00);

      // ---- req1 error on first of 4 bursts ----
      req_valid  = 2'b10;
      req_mode   = 2'b10;
      req_base   = {32'h0000_2000, 32'd0};
      req_nburst = {16'd4, 16'd0};
      tick();
      req_valid = 2'b00;
      check("t5_ack", req_ack, 32'h2);
      serve_burst("t5_b0", 2'b10, 32'h0000_2000, 1'b1, 4'b1011, 2'b10, 2'b00);
      check("t5_err",    err,     32'hB);
      check("t5_errsrc", err_src, 32'h2);
      repeat (5) tick();
      check("t5_no_more", ddr_req, 32'd0);
      check("t5_sticky",  err,     32'hB);
      // a new accept clears the sticky error
      req_valid  = 2'b01;
      req_nburst = {16'd0, 16'd0};
      tick();
      req_valid = 2'b00;
      check("t5_ack2",   req_ack, 32'h1);
      check("t5_errclr", err,     32'h0);
      check("t5_srcclr", err_src, 32'h0);
      tick();
      check("t5_done2", req_done, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ninjin_ddr_sched.md
NINJIN_DDR_SCHED -- requirements
Module: ninjin_ddr_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, beats per AXI burst issued by the downstream image master.
REQ-002 SHALL have parameter DWIDTH, default 32, data width in bits; burst stride in bytes is BURST_BYTES = BURST_LEN*DWIDTH/8.
REQ-003 SHALL have parameter MEMSIZE, default 32, DDR byte-address width.
REQ-004 SHALL have parameter CNTW, default 16, width of the burst-count field.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: req_valid  in  2  per-requester transfer request; req_mode  in  2  per requester, 0=read, 1=write; req_base  in  2*MEMSIZE  start byte address, requester i at bits [i*MEMSIZE +: MEMSIZE]; req_nburst  in  2*CNTW  burst count, packed the same way.
REQ-007 SHALL have ports: req_ack  out  2  one-cycle accept pulse; req_done  out  2  one-cycle completion pulse; req_busy  out  2  slot occupied; grant  out  2  one-hot owner of the in-flight burst.
REQ-008 SHALL have ports: ddr_req  out  1  burst request to master; ddr_mode  out  1  direction; ddr_base  out  MEMSIZE  burst address; ddr_done  in  1  burst-complete pulse; ddr_err  in  4  master error code, valid with ddr_done; err  out  4  sticky error; err_src  out  2  one-hot requester that erred.

Function
REQ-009 SHALL hold one slot per requester (mode, base, remaining count); slot i is accepted when req_valid[i]=1 and req_busy[i]=0; fields are latched at that edge, with req_ack[i]=1 and req_busy[i]=1 in the next cycle.
REQ-010 SHALL ignore req_valid[i] while req_busy[i]=1, with no ack.
REQ-011 SHALL complete a slot accepted with nburst=0 without a DDR access: req_done[i] one cycle after req_ack[i], then busy clears.
REQ-012 SHALL implement FSM S_IDLE -> S_ISSUE -> S_WAIT -> S_IDLE; S_IDLE leaves only when at least one slot is busy with remaining>0.
REQ-013 SHALL arbitrate in S_IDLE round-robin at burst granularity: requester 0 has priority after reset; after each completed burst the requester just served gets lowest priority.
REQ-014 SHALL, in S_ISSUE and S_WAIT, drive grant one-hot to the selected slot, ddr_mode = slot mode, and ddr_base = slot current base; grant is 0 in S_IDLE.
REQ-015 SHALL drive ddr_req=1 in S_ISSUE and S_WAIT up to and including the ddr_done cycle, and 0 otherwise, guaranteeing at least one low cycle between bursts so the master sees a fresh rising edge.
REQ-016 SHALL, on ddr_done with ddr_err=0 in S_WAIT: add BURST_BYTES to slot base modulo 2^MEMSIZE, decrement remaining, and return to S_IDLE; if remaining becomes 0, pulse req_done the next cycle and clear busy in that same cycle.
REQ-017 SHALL, on ddr_done with ddr_err!=0: latch err=ddr_err and err_src=grant (sticky), abort the slot (busy cleared, req_done pulsed the next cycle), and return to S_IDLE; other slots continue.
REQ-018 SHALL ignore ddr_done outside S_WAIT.
REQ-019 SHALL, when req_done[i] and req_valid[i] occur in the same cycle, accept the new request on the following edge; no accept occurs while busy[i]=1.
REQ-020 SHALL clear err and err_src on any req_ack pulse.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, set: FSM to S_IDLE, all slots empty, priority to requester 0, and outputs ddr_req, ddr_mode, ddr_base, grant, req_ack, req_done, req_busy, err, err_src all 0; any in-flight burst is dropped.
REQ-022 SHALL accept no requests and ignore ddr_done while rst=1.

Verification
REQ-023 Requester 0 write, base 0x1000, nburst 3, 1 pulse ack, then ddr_done 10 cycles after each ddr_req rise -> ddr_base 0x1000, 0x1400, 0x1800; ddr_mode=1; one req_done[0] after the third burst.
REQ-024 Both requesters valid in the same cycle, nburst 2 each, bases 0x0 (read) and 0x8000 (write) -> grant order 01, 10, 01, 10; ddr_base 0x0, 0x8000, 0x400, 0x8400; ddr_req low at least 1 cycle between bursts.
REQ-025 Requester 1, nburst 0 -> req_ack[1], then req_done[1] the next cycle; ddr_req never asserted.
REQ-026 Requester 0, base 0xFFFFFC00, nburst 2 -> second ddr_base = 0x00000000 (wrap).
REQ-027 ddr_done with ddr_err=4'b1011 on requester 1's first of 4 bursts -> err=4'b1011, err_src=10, req_done[1] pulse, busy[1]=0, no further requester 1 bursts.
REQ-028 rst=1 asserted during S_WAIT -> next cycle ddr_req=0, busy=00, grant=00; a later ddr_done has no effect.
